// File: rtl/serial_byte_rx.sv
// -----------------------------------------------------------------------------
// serial_byte_rx
//
// Serial byte receiver that sits behind the start-bit detector. While the
// detector holds `en` high (DATA_W consecutive cycles per frame) the raw
// serial line is shifted in LSB-first. The cycle after `en` falls is the stop
// cycle: the stop bit is sampled there and a good frame is committed into a
// single-entry holding register that the consumer drains with rx_valid /
// rx_ready. Bad windows raise a one-cycle frame_err pulse. A byte that
// completes while the holding register is still full is dropped and flagged
// on the sticky overrun output.
//
// Build option:
//   FRAME_CHECK_EN  when defined, a stop bit of 0 is a framing error (no
//                   commit) and the err_cnt output counts frame_err pulses.
//                   When undefined, the stop bit is not checked and err_cnt
//                   is not present.
//
// Parameters:
//   DATA_W     data bits per frame (equals the upstream en high-time)
//   CNT_W      width of frame_cnt / err_cnt
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   data       serial line
//   en         bit-window strobe from the start-bit detector
//   rx_ready   consumer accepts rx_data on this edge
//   ovr_clr    single-cycle pulse clearing the sticky overrun flag
//   rx_data    held byte, meaningful while rx_valid = 1
//   rx_valid   holding register full
//   overrun    sticky, a completed byte was dropped
//   frame_err  one-cycle pulse, a frame was discarded
//   frame_cnt  bytes committed to the holding register (wraps)
//   err_cnt    frame_err pulses seen (wraps, FRAME_CHECK_EN builds only)
// -----------------------------------------------------------------------------
module serial_byte_rx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data,
    input  logic              en,
    input  logic              rx_ready,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              overrun,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt
`ifdef FRAME_CHECK_EN
    ,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    // bit_cnt has to hold the value DATA_W itself, hence the +1
    localparam int BCW = $clog2(DATA_W + 1);

    localparam logic [BCW-1:0]   BIT_FULL = BCW'(DATA_W);
    localparam logic [BCW-1:0]   BIT_ONE  = BCW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ST_ABORT swallows the tail of an over-long window so that a new frame
    // can only begin on a fresh rising edge of en.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_ABORT = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   shreg_r;
    logic [BCW-1:0]      bit_cnt_r;
    logic [BCW-1:0]      bit_cnt_s;
    logic [DATA_W-1:0]   rx_data_r;
    logic                rx_valid_r;
    logic                overrun_r;
    logic                frame_err_r;
    logic [CNT_W-1:0]    frame_cnt_r;

    logic                full_s;
    logic                stop_s;
    logic                good_s;
    logic                err_s;
    logic                commit_s;
    logic                drop_s;
    logic                xfer_s;

    assign full_s = (bit_cnt_r == BIT_FULL);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    if (full_s) begin
                        state_s = ST_ABORT;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    // Stop cycle or short window: either way the frame ends
                    state_s = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (en) begin
                    state_s = ST_ABORT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output / control decode: bit counter update, frame verdict, handshake
    always_comb begin
        bit_cnt_s = '0;
        stop_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    bit_cnt_s = BIT_ONE;
                end else begin
                    bit_cnt_s = '0;
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    if (full_s) begin
                        // window longer than DATA_W
                        err_s     = 1'b1;
                        bit_cnt_s = '0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    bit_cnt_s = '0;
                    if (full_s) begin
                        stop_s = 1'b1;
                    end else begin
                        // window shorter than DATA_W
                        err_s = 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                bit_cnt_s = '0;
            end
            default: begin
                bit_cnt_s = '0;
            end
        endcase

`ifdef FRAME_CHECK_EN
        // the line must be idle-high during the stop cycle
        if (stop_s && !data) begin
            good_s = 1'b0;
            err_s  = 1'b1;
        end else begin
            good_s = stop_s;
        end
`else
        good_s = stop_s;
`endif

        // the holding register can take a byte if it is empty or draining now
        xfer_s   = rx_valid_r & rx_ready;
        commit_s = good_s & (~rx_valid_r | rx_ready);
        drop_s   = good_s & rx_valid_r & ~rx_ready;
    end

    // Shift register and bit counter; every en edge shifts, first bit ends at [0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r   <= '0;
            bit_cnt_r <= '0;
        end else begin
            bit_cnt_r <= bit_cnt_s;
            if (en) begin
                shreg_r <= {data, shreg_r[DATA_W-1:1]};
            end else begin
                shreg_r <= shreg_r;
            end
        end
    end

    // Holding register; rx_data only moves on a commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
        end else begin
            if (commit_s) begin
                rx_data_r  <= shreg_r;
                rx_valid_r <= 1'b1;
            end else if (xfer_s) begin
                rx_data_r  <= rx_data_r;
                rx_valid_r <= 1'b0;
            end else begin
                rx_data_r  <= rx_data_r;
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else begin
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Registered one-cycle framing error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= err_s;
        end
    end

    // Committed-byte counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= '0;
        end else begin
            if (commit_s) begin
                frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

`ifdef FRAME_CHECK_EN
    logic [CNT_W-1:0] err_cnt_r;

    // Error counter follows the registered pulse so the two stay in step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else begin
            if (frame_err_r) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign err_cnt = err_cnt_r;
`endif

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;
    assign frame_cnt = frame_cnt_r;

endmodule
